// File: rtl/count_uart_reporter_pkg.sv
// count_uart_pkg: shared types and constants for the count UART reporter.
//   tx_state_e      - character serializer states
//   ASCII_*         - character constants used to build the report frame
//   nibble_to_hex   - 4-bit value to uppercase ASCII hex digit
// The PARITY state is only reached when REPORT_PARITY_EN is defined.
package count_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    if (nib < 4'd10) begin
      return ASCII_0 + wide;
    end
    return ASCII_A + (wide - 8'd10);
  endfunction

endpackage

// File: rtl/count_uart_reporter_tx_byte.sv
// uart_tx_byte: serializes one byte onto a UART line.
// Format: start bit (0), 8 data bits LSB first, optional even parity bit
// (REPORT_PARITY_EN), stop bit (1); every bit lasts CLKS_PER_BIT cycles.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   load, data     - byte accepted in any cycle where ready is high
//   ready          - idle, or in the last cycle of a stop bit (allows a
//                    following character with no idle gap)
//   stop_end_next  - next cycle is the last cycle of the stop bit
//   tx             - serial output, idle high
module uart_tx_byte
  import count_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       stop_end_next,
  output logic       tx
);

  localparam int unsigned    CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_PENULT = CW'(CLKS_PER_BIT - 2);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
`ifdef REPORT_PARITY_EN
  logic          par_q, par_d;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
`ifdef REPORT_PARITY_EN
    par_d     = par_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (load) begin
          state_d = START;
          tx_d    = 1'b0;
          cnt_d   = '0;
          shreg_d = data;
`ifdef REPORT_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 4'd7) begin
`ifdef REPORT_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end
      end
`ifdef REPORT_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          // A byte offered on the final stop cycle starts immediately.
          if (load) begin
            state_d = START;
            tx_d    = 1'b0;
            shreg_d = data;
`ifdef REPORT_PARITY_EN
            par_d   = ^data;
`endif
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
`ifdef REPORT_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
`ifdef REPORT_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign ready         = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign stop_end_next = (state_q == STOP) && (cnt_q == CNT_PENULT);
  assign tx            = tx_q;

endmodule

// File: rtl/count_uart_reporter.sv
// count_uart_reporter: reports an 8-bit counter value over UART whenever it
// changes, as two uppercase hex characters followed by CR LF.
// Optional even parity per character with REPORT_PARITY_EN.
// Ports:
//   hw_clk     - system clock
//   rst        - asynchronous active-high reset
//   value      - counter value to report (may show multi-bit skew)
//   uart_tx    - UART serial line, idle high
//   busy       - high while a frame is in progress
//   frame_done - one-cycle pulse on the last cycle of the final stop bit
module count_uart_reporter
  import count_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 12000000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       hw_clk,
  input  logic       rst,
  input  logic [7:0] value,
  output logic       uart_tx,
  output logic       busy,
  output logic       frame_done
);

  logic [7:0] v_q, v_d;
  logic [7:0] last_sent_q, last_sent_d;
  logic [7:0] snapshot_q, snapshot_d;
  logic       primed_q, primed_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic [1:0] char_idx_q, char_idx_d;

  logic       tx_ready;
  logic       tx_stop_end_next;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       stable;
  logic       trigger;

  function automatic logic [7:0] char_byte(input logic [1:0] idx,
                                           input logic [7:0] snap);
    case (idx)
      2'd0:    return nibble_to_hex(snap[7:4]);
      2'd1:    return nibble_to_hex(snap[3:0]);
      2'd2:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  // Two equal consecutive samples reject transient skew on value.
  assign stable  = (value == v_q);
  assign trigger = !busy_q && tx_ready && stable &&
                   (!primed_q || (v_q != last_sent_q));

  always_comb begin
    v_d          = value;
    last_sent_d  = last_sent_q;
    snapshot_d   = snapshot_q;
    primed_d     = primed_q;
    busy_d       = busy_q;
    char_idx_d   = char_idx_q;
    frame_done_d = 1'b0;
    tx_load      = 1'b0;
    tx_data      = '0;

    if (trigger) begin
      // First character comes straight from v_q so the start bit is
      // driven on the very next cycle.
      tx_load     = 1'b1;
      tx_data     = char_byte(2'd0, v_q);
      snapshot_d  = v_q;
      last_sent_d = v_q;
      primed_d    = 1'b1;
      busy_d      = 1'b1;
      char_idx_d  = 2'd0;
    end else if (busy_q) begin
      if (tx_ready) begin
        if (char_idx_q != 2'd3) begin
          tx_load    = 1'b1;
          tx_data    = char_byte(char_idx_q + 2'd1, snapshot_q);
          char_idx_d = char_idx_q + 2'd1;
        end else begin
          busy_d = 1'b0;
        end
      end
      // Registered one cycle early so the pulse lands on the final stop cycle.
      frame_done_d = tx_stop_end_next && (char_idx_q == 2'd3);
    end
  end

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      v_q          <= '0;
      last_sent_q  <= '0;
      snapshot_q   <= '0;
      primed_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      char_idx_q   <= '0;
    end else begin
      v_q          <= v_d;
      last_sent_q  <= last_sent_d;
      snapshot_q   <= snapshot_d;
      primed_q     <= primed_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      char_idx_q   <= char_idx_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk           (hw_clk),
    .rst           (rst),
    .load          (tx_load),
    .data          (tx_data),
    .ready         (tx_ready),
    .stop_end_next (tx_stop_end_next),
    .tx            (uart_tx)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_count_uart_reporter.sv
// Testbench for count_uart_reporter (CLK_HZ=1000, BAUD=100 -> 10 cycles/bit).
// A line monitor decodes characters and checks them against a scoreboard of
// expected bytes; it also checks busy length and frame_done per frame.
module tb_count_uart_reporter;

`ifdef REPORT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int CPB       = 10;
  localparam int FRAME_CYC = 4 * NB * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] value;
  logic       uart_tx;
  logic       busy;
  logic       frame_done;

  int tests;
  int fails;
  int frames_seen;

  logic [7:0] exp_q[$];
  string      hexd;

  logic       mon_active;
  int         mon_cnt;
  logic [7:0] rx;
  logic       start_bit, stop_bit, par_bit;
  logic       prev_tx, prev_busy, prev_fd;
  int         busy_run, fd_run;

  count_uart_reporter #(
    .CLK_HZ (1000),
    .BAUD   (100)
  ) dut (
    .hw_clk     (clk),
    .rst        (rst),
    .value      (value),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_frame(input logic [7:0] v);
    exp_q.push_back(8'(hexd[v[7:4]]));
    exp_q.push_back(8'(hexd[v[3:0]]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && !mon_active && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Line monitor / scoreboard consumer.
  initial begin
    mon_active = 1'b0; mon_cnt = 0; rx = '0;
    start_bit = 1'b1; stop_bit = 1'b0; par_bit = 1'b0;
    prev_tx = 1'b1; prev_busy = 1'b0; prev_fd = 1'b0;
    busy_run = 0; fd_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
        busy_run   = 0;
        fd_run     = 0;
      end else begin
        if (!mon_active && prev_tx && !uart_tx) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
        end else if (mon_active) begin
          mon_cnt++;
        end
        if (mon_active && (mon_cnt % CPB) == CPB / 2) begin
          int k;
          k = mon_cnt / CPB;
          if (k == 0) start_bit = uart_tx;
          else if (k <= 8) rx[k-1] = uart_tx;
          else if (k < NB - 1) par_bit = uart_tx;
          if (k == NB - 1) begin
            logic [7:0] e;
            stop_bit = uart_tx;
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL rx_unexpected: got byte %02h, none expected", rx);
            end else begin
              e = exp_q.pop_front();
              if ({start_bit, rx, stop_bit} !== {1'b0, e, 1'b1}) begin
                fails++;
                $display("FAIL rx_byte: got %02h start=%b stop=%b, expected %02h start=0 stop=1",
                         rx, start_bit, stop_bit, e);
              end
`ifdef REPORT_PARITY_EN
              tests++;
              if (par_bit !== ^e) begin
                fails++;
                $display("FAIL rx_parity: byte %02h parity %b, expected %b", e, par_bit, ^e);
              end
`endif
            end
          end
        end
        if (mon_active && mon_cnt == NB * CPB - 1) mon_active = 1'b0;

        if (busy) begin
          busy_run++;
          if (frame_done) fd_run++;
        end else begin
          if (frame_done) begin
            tests++; fails++;
            $display("FAIL frame_done_idle: frame_done=1 while busy=0");
          end
          if (prev_busy) begin
            tests++;
            if (busy_run !== FRAME_CYC || fd_run !== 1 || prev_fd !== 1'b1) begin
              fails++;
              $display("FAIL frame_len: busy %0d cycles, %0d frame_done pulses, last=%b; expected %0d, 1, 1",
                       busy_run, fd_run, prev_fd, FRAME_CYC);
            end
            frames_seen++;
            busy_run = 0;
            fd_run   = 0;
          end
        end
      end
      prev_tx   = uart_tx;
      prev_busy = busy;
      prev_fd   = frame_done;
    end
  end

  task automatic test_reset;
    bit ok;
    rst   = 1'b1;
    value = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if ({uart_tx, busy, frame_done} !== 3'b100) begin
      fails++;
      $display("FAIL reset_state: tx/busy/fd=%b, expected 100", {uart_tx, busy, frame_done});
    end
    push_frame(8'h00);
    rst = 1'b0;
    wait_idle(1000, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL reset_frame: timeout, %0d bytes pending, expected 0", exp_q.size());
    end
    tests++;
    if (frames_seen !== 1) begin
      fails++;
      $display("FAIL reset_frame_count: %0d frames, expected 1", frames_seen);
    end
  endtask

  task automatic test_hex_latency;
    bit ok;
    int n;
    n = 0;
    @(posedge clk);
    #1 value = 8'h3C;
    push_frame(8'h3C);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!uart_tx) begin
        n = i;
        break;
      end
    end
    tests++;
    if (n !== 3) begin
      fails++;
      $display("FAIL start_latency: start bit at negedge %0d after change, expected 3", n);
    end
    wait_idle(1000, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL hex_frame: timeout, %0d bytes pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit seen;
    int f0;
    f0 = frames_seen;
    seen = 1'b0;
    @(negedge clk);
    value = 8'h10;
    push_frame(8'h10);
    push_frame(8'h12);
    repeat (100) @(negedge clk);
    value = 8'h11;
    repeat (100) @(negedge clk);
    value = 8'h12;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL b2b_frame_done: no frame_done within 600 cycles, expected one");
    end
    @(negedge clk);
    tests++;
    if ({busy, uart_tx} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_gap: busy/tx=%b, expected 01", {busy, uart_tx});
    end
    @(negedge clk);
    tests++;
    if ({busy, uart_tx} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_restart: busy/tx=%b, expected 10", {busy, uart_tx});
    end
    wait_idle(1000, ok);
    tests++;
    if (!ok || frames_seen - f0 !== 2) begin
      fails++;
      $display("FAIL b2b_frames: ok=%b frames=%0d pending=%0d, expected ok=1 frames=2 pending=0",
               ok, frames_seen - f0, exp_q.size());
    end
  endtask

  task automatic test_hold;
    int bad;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_idle: %0d cycles with activity, expected 0", bad);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    @(negedge clk);
    value = 8'hFF;
    push_frame(8'hFF);
    wait_idle(1000, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wrap_ff: timeout, %0d bytes pending, expected 0", exp_q.size());
    end
    value = 8'h00;
    push_frame(8'h00);
    wait_idle(1000, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wrap_00: timeout, %0d bytes pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int f0;
    int n;
    n = 0;
    @(negedge clk);
    value = 8'hA5;
    push_frame(8'hA5);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!uart_tx) begin
        n = i;
        break;
      end
    end
    tests++;
    if (n == 0) begin
      fails++;
      $display("FAIL mid_start: no start bit within 20 cycles, expected one");
    end
    repeat (55) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({uart_tx, busy} !== 2'b10) begin
      fails++;
      $display("FAIL mid_reset: tx/busy=%b, expected 10", {uart_tx, busy});
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    f0 = frames_seen;
    push_frame(8'hA5);
    rst = 1'b0;
    wait_idle(1000, ok);
    tests++;
    if (!ok || frames_seen - f0 !== 1) begin
      fails++;
      $display("FAIL mid_resend: ok=%b frames=%0d pending=%0d, expected ok=1 frames=1 pending=0",
               ok, frames_seen - f0, exp_q.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    frames_seen = 0;
    hexd = "0123456789ABCDEF";
    rst = 1'b1;
    value = 8'h00;
    test_reset();
    test_hex_latency();
    test_back_to_back();
    test_hold();
    test_wrap();
    test_reset_mid();
`ifdef REPORT_PARITY_EN
    begin
      bit ok;
      @(negedge clk);
      value = 8'h07;
      push_frame(8'h07);
      wait_idle(1500, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL parity_frame: timeout, %0d bytes pending, expected 0", exp_q.size());
      end
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
